ula_operador_auto: RTL and testbench
====================================

Name: ula_operador_auto

Overview:
- Hardware operator that drives the switch/button interface of projeto_ula_fsm (SW[2:0], KEY[0] active-low), the initiating side of that protocol.
- On a start pulse it walks the ULA FSM through start, load A, load B, load OP, then samples the LEDR result and flags, compares against an expected value, and presses once more to return the ULA to idle.
- Used for on-board self-test and as a reusable stimulus source in simulation.

Parameters:
- SETUP_CYCLES, 1, cycles SW is held stable before each press (>=1)
- HOLD_CYCLES, 3, cycles KEY[0] is held low per press (>=1)
- GAP_CYCLES, 3, cycles KEY[0] is held high after each release (>=1)
- RESULT_WAIT, 5, cycles waited after the OP press gap before sampling LEDR (>=1)

Ports:
- CLOCK_50  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- op_a  in  3  operand A
- op_b  in  3  operand B
- op_code  in  3  ULA operation code
- expected  in  6  expected LEDR[5:0] result
- LEDR_in  in  10  LEDR from the ULA; [5:0] result, [6] zero flag
- SW  out  3  switch value presented to the ULA
- KEY  out  1  button to the ULA, active-low (1 = released)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  comparison result of the last run
- result  out  6  captured LEDR_in[5:0]
- zero_flag  out  1  captured LEDR_in[6]

Behaviour:
- Reset (sync, active-high): SW=0, KEY=1, busy=0, done=0, pass=0, result=0, zero_flag=0, state=IDLE, step=0, counter=0. Reset mid-run aborts on the next edge with the same values. The ULA is not reset by this block.
- Accept: start=1 in IDLE at edge N latches op_a, op_b, op_code, expected, clears pass/result/zero_flag, sets step=0, and enters SETUP. busy=1 from N+1. start is ignored while not in IDLE.
- Steps and SW values: 0 START SW=0; 1 LOAD_A SW=op_a; 2 LOAD_B SW=op_b; 3 LOAD_OP SW=op_code; 4 RETURN SW=0.
- Per step: SETUP (SETUP_CYCLES, KEY=1, SW=step value), then PRESS (HOLD_CYCLES, KEY=0), then GAP (GAP_CYCLES, KEY=1). SW is constant from SETUP entry through GAP end.
- After step 3 GAP: WAIT_RES for RESULT_WAIT cycles, then SAMPLE for 1 cycle.
- SAMPLE: result=LEDR_in[5:0]; zero_flag=LEDR_in[6]; pass = (LEDR_in[5:0]==expected) && (LEDR_in[6]==(expected==0)). Then step 4.
- After step 4 GAP: DONE for 1 cycle with done=1 and busy=0, then IDLE.
- Latency: DONE is entered at edge N+1+5*(S+H+G)+W+1. With defaults this is N+42.
- result, zero_flag and pass hold until the next accept or reset. SW returns to 0 in IDLE and KEY=1.
- Back-to-back: start held high re-accepts at the first IDLE cycle after DONE.
- The phase counter is sized with $clog2 of the maximum parameter. It loads value-1 on phase entry and advances the phase at 0.

Decomposition:
- Package ula_pkg: state enum (IDLE, SETUP, PRESS, GAP, WAIT_RES, SAMPLE, DONE), step codes 0..4, and the ULA op encodings (OP_MULT=3'b010 plus the remaining ULA ops), shared with projeto_ula_fsm.
- One sub-module: ula_contador_fase, a loadable down-counter with a terminal-count output, used for every timed phase.

Test Plan:
- Real projeto_ula_fsm attached, A=5, B=3, OP=010, expected=15 -> four KEY low windows of exactly 3 cycles, result=15, zero_flag=0, pass=1, done at N+42, ULA back in idle.
- Same run with expected=14 -> result=15, pass=0, done still at N+42.
- A=0, B=3, OP=010, expected=0 -> result=0, zero_flag=1, pass=1.
- start re-pulsed during step 2 -> no effect, single done. start held high -> second run accepted the cycle after DONE.
- RESET asserted during step-2 PRESS -> next edge KEY=1, SW=0, busy=0, pass=0. After the ULA is also reset, a new start completes with pass=1.
- Override S=H=G=W=1 -> each KEY low lasts 1 cycle, done at N+18.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA operator and projeto_ula_fsm: sequencer states,
// step codes and the ULA operation encodings.
package ula_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PRESS,
        ST_GAP,
        ST_WAIT_RES,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [2:0] STEP_START   = 3'd0;
    localparam logic [2:0] STEP_LOAD_A  = 3'd1;
    localparam logic [2:0] STEP_LOAD_B  = 3'd2;
    localparam logic [2:0] STEP_LOAD_OP = 3'd3;
    localparam logic [2:0] STEP_RETURN  = 3'd4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ula_operador_auto_contador.sv
// Loadable down-counter with terminal-count flag; times every sequencer phase.
module ula_contador_fase #(
    parameter int W = 2
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/ula_operador_auto.sv
// Drives projeto_ula_fsm through start / load A / load B / load OP, checks LEDR, returns it to idle.
// state    | meaning
// IDLE     | waiting for start, SW=0, KEY released
// SETUP    | SW presented for the current step, KEY released
// PRESS    | KEY held low
// GAP      | KEY released after a press
// WAIT_RES | settling time before reading LEDR
// SAMPLE   | capture LEDR and compare
// DONE     | one-cycle done pulse
module ula_operador_auto
    import ula_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 3,
    parameter int GAP_CYCLES   = 3,
    parameter int RESULT_WAIT  = 5
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       start,
    input  logic [2:0] op_a,
    input  logic [2:0] op_b,
    input  logic [2:0] op_code,
    input  logic [5:0] expected,
    input  logic [9:0] LEDR_in,
    output logic [2:0] SW,
    output logic       KEY,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] result,
    output logic       zero_flag
);

    localparam int CNT_MAX = max_of4(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES, RESULT_WAIT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The accept cycle is folded into the first SETUP so the latched operands are settled.
    localparam logic [CNT_W-1:0] LD_ACCEPT = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_WAIT   = CNT_W'(RESULT_WAIT - 1);

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [2:0] a_q, a_d, b_q, b_d, op_q, op_d;
    logic [5:0] exp_q, exp_d;
    logic       pass_q, pass_d;
    logic [5:0] result_q, result_d;
    logic       zero_q, zero_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_tc;
    logic [2:0]       step_sw;
    logic             ledr_unused;

    assign ledr_unused = ^LEDR_in[9:7];

    ula_contador_fase #(.W(CNT_W)) u_contador (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        exp_d    = exp_q;
        pass_d   = pass_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    op_d     = op_code;
                    exp_d    = expected;
                    pass_d   = 1'b0;
                    result_d = '0;
                    zero_d   = 1'b0;
                    step_d   = STEP_START;
                    state_d  = ST_SETUP;
                    cnt_load = 1'b1;
                    cnt_val  = LD_ACCEPT;
                end
            end
            ST_SETUP: begin
                if (cnt_tc) begin
                    state_d  = ST_PRESS;
                    cnt_load = 1'b1;
                    cnt_val  = LD_HOLD;
                end
            end
            ST_PRESS: begin
                if (cnt_tc) begin
                    state_d  = ST_GAP;
                    cnt_load = 1'b1;
                    cnt_val  = LD_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_tc) begin
                    if (step_q == STEP_LOAD_OP) begin
                        state_d  = ST_WAIT_RES;
                        cnt_load = 1'b1;
                        cnt_val  = LD_WAIT;
                    end else if (step_q == STEP_RETURN) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d   = step_q + 3'd1;
                        state_d  = ST_SETUP;
                        cnt_load = 1'b1;
                        cnt_val  = LD_SETUP;
                    end
                end
            end
            ST_WAIT_RES: begin
                if (cnt_tc) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                result_d = LEDR_in[5:0];
                zero_d   = LEDR_in[6];
                pass_d   = (LEDR_in[5:0] == exp_q) && (LEDR_in[6] == (exp_q == 6'd0));
                step_d   = STEP_RETURN;
                state_d  = ST_SETUP;
                cnt_load = 1'b1;
                cnt_val  = LD_SETUP;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (step_q)
            STEP_LOAD_A:  step_sw = a_q;
            STEP_LOAD_B:  step_sw = b_q;
            STEP_LOAD_OP: step_sw = op_q;
            default:      step_sw = 3'd0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            step_q   <= STEP_START;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            exp_q    <= '0;
            pass_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            exp_q    <= exp_d;
            pass_q   <= pass_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign SW        = (state_q == ST_IDLE) ? 3'd0 : step_sw;
    assign KEY       = (state_q != ST_PRESS);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign result    = result_q;
    assign zero_flag = zero_q;

endmodule

// File: tb/tb_ula_operador_auto.sv
// Bench for ula_operador_auto: a behavioural ULA answers the button protocol, runs are checked
// against latency, press widths and result/pass computed from the operation arithmetic.
module tb_ula_operador_auto;

    localparam int S = 1, H = 3, G = 3, W = 5;
    localparam int LAT  = 1 + 5 * (S + H + G) + W + 1;
    localparam int LAT2 = 1 + 5 * 3 + 1 + 1;

    logic       clk = 1'b0;
    logic       rst, ula_rst, start, start2;
    logic [2:0] op_a, op_b, op_code;
    logic [5:0] expected;
    logic [9:0] ledr, ledr2;
    logic [2:0] sw, sw2;
    logic       key, key2, busy, busy2, done, done2, pass, pass2, zero_flag, zero2;
    logic [5:0] result, result2;

    int n_vec = 0, n_err = 0;
    int cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ula_operador_auto dut (
        .CLOCK_50(clk), .RESET(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .op_code(op_code), .expected(expected), .LEDR_in(ledr), .SW(sw), .KEY(key),
        .busy(busy), .done(done), .pass(pass), .result(result), .zero_flag(zero_flag)
    );

    ula_operador_auto #(.SETUP_CYCLES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .RESULT_WAIT(1)) dut2 (
        .CLOCK_50(clk), .RESET(rst), .start(start2), .op_a(3'd0), .op_b(3'd3),
        .op_code(3'b010), .expected(6'd0), .LEDR_in(ledr2), .SW(sw2), .KEY(key2),
        .busy(busy2), .done(done2), .pass(pass2), .result(result2), .zero_flag(zero2)
    );

    function automatic logic [5:0] ula_calc(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
        int r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a * b;
            3'b011:  r = a & b;
            3'b100:  r = a | b;
            3'b101:  r = a ^ b;
            3'b110:  r = 7 - a;
            default: r = a;
        endcase
        return 6'(r & 63);
    endfunction

    // Behavioural projeto_ula_fsm: idle -> wait A -> wait B -> wait OP -> show -> idle, one step per press.
    int         ula_st;
    logic [2:0] ua, ub;
    logic [5:0] ures;
    logic       key_prev;

    always @(posedge clk) begin
        if (ula_rst) begin
            ula_st   <= 0;
            key_prev <= 1'b1;
            ures     <= 6'd0;
            ua       <= 3'd0;
            ub       <= 3'd0;
        end else begin
            key_prev <= key;
            if (key_prev && !key) begin
                case (ula_st)
                    0: ula_st <= 1;
                    1: begin ua <= sw; ula_st <= 2; end
                    2: begin ub <= sw; ula_st <= 3; end
                    3: begin ures <= ula_calc(ua, ub, sw); ula_st <= 4; end
                    default: ula_st <= 0;
                endcase
            end
        end
    end

    assign ledr  = (ula_st == 4) ? {3'b000, (ures == 6'd0), ures} : 10'd0;
    assign ledr2 = 10'h040;

    int widths[$];
    int widths2[$];
    int low_run = 0, low_run2 = 0;
    int done_cnt = 0, done_cyc = 0, done2_cnt = 0, done2_cyc = 0;

    always @(negedge clk) begin
        if (key === 1'b0) low_run++;
        else if (low_run != 0) begin widths.push_back(low_run); low_run = 0; end
        if (key2 === 1'b0) low_run2++;
        else if (low_run2 != 0) begin widths2.push_back(low_run2); low_run2 = 0; end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (done2 === 1'b1) begin done2_cnt++; done2_cyc = cyc; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                          input logic [5:0] ex, output int n_acc);
        @(negedge clk);
        op_a = a; op_b = b; op_code = op; expected = ex;
        start = 1'b1;
        n_acc = cyc + 1;
        widths.delete();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev_cnt, input string tag);
        int k;
        k = 0;
        while (done_cnt == prev_cnt && k < 200) begin @(negedge clk); k++; end
        if (done_cnt == prev_cnt) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_ula_st(input int st, input string tag);
        int k;
        k = 0;
        while (ula_st != st && k < 200) begin @(negedge clk); k++; end
        if (ula_st != st) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_and_check(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                                 input logic [5:0] ex, input string tag);
        int n, d0;
        logic [5:0] ref_res;
        logic ref_pass;
        ref_res  = ula_calc(a, b, op);
        ref_pass = (ref_res == ex) && ((ref_res == 6'd0) == (ex == 6'd0));
        d0 = done_cnt;
        launch(a, b, op, ex, n);
        check({tag, "_busy"}, busy, 1);
        wait_done(d0, tag);
        check({tag, "_latency"}, done_cyc - n, LAT);
        check({tag, "_result"}, result, ref_res);
        check({tag, "_zero"}, zero_flag, ref_res == 6'd0);
        check({tag, "_pass"}, pass, ref_pass);
        check({tag, "_npress"}, widths.size(), 5);
        foreach (widths[i]) check({tag, "_presswidth"}, widths[i], H);
        @(negedge clk);
        check({tag, "_ula_idle"}, ula_st, 0);
        check({tag, "_idle_sw"}, sw, 0);
        check({tag, "_idle_key"}, key, 1);
    endtask

    initial begin
        int n, d0, d1, k;
        logic [2:0] ra, rb, rop;
        logic [5:0] rex;

        rst = 1'b1; ula_rst = 1'b1; start = 1'b0; start2 = 1'b0;
        op_a = 3'd0; op_b = 3'd0; op_code = 3'd0; expected = 6'd0;
        repeat (3) @(negedge clk);
        check("rst_sw", sw, 0);
        check("rst_key", key, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero_flag, 0);
        rst = 1'b0; ula_rst = 1'b0;
        @(negedge clk);

        run_and_check(3'd5, 3'd3, 3'b010, 6'd15, "mult_ok");
        run_and_check(3'd5, 3'd3, 3'b010, 6'd14, "mult_bad");
        run_and_check(3'd0, 3'd3, 3'b010, 6'd0, "mult_zero");

        for (int i = 0; i < 6; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rb  = 3'($urandom_range(0, 7));
            rop = 3'($urandom_range(0, 7));
            rex = ula_calc(ra, rb, rop);
            if ($urandom_range(0, 1) == 1) rex = rex ^ 6'($urandom_range(1, 63));
            run_and_check(ra, rb, rop, rex, "rand");
        end

        // start re-pulsed during step 2
        d0 = done_cnt;
        launch(3'd6, 3'd2, 3'b000, 6'd8, n);
        wait_ula_st(3, "repulse");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, "repulse");
        check("repulse_latency", done_cyc - n, LAT);
        repeat (60) @(negedge clk);
        check("repulse_single_done", done_cnt - d0, 1);
        check("repulse_pass", pass, 1);

        // start held high: second run accepted in the IDLE cycle after DONE
        d0 = done_cnt;
        @(negedge clk);
        op_a = 3'd7; op_b = 3'd7; op_code = 3'b010; expected = 6'd49;
        start = 1'b1;
        n = cyc + 1;
        wait_done(d0, "held1");
        d1 = done_cyc;
        check("held_first_latency", d1 - n, LAT);
        wait_done(d0 + 1, "held2");
        start = 1'b0;
        check("held_second_latency", done_cyc - d1, LAT + 2);
        check("held_second_pass", pass, 1);
        check("held_second_result", result, 49);
        repeat (5) @(negedge clk);
        check("held_stop_busy", busy, 0);

        // reset during step-2 press
        d0 = done_cnt;
        launch(3'd5, 3'd3, 3'b010, 6'd15, n);
        wait_ula_st(3, "abort");
        check("abort_in_press", key, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_key", key, 1);
        check("abort_sw", sw, 0);
        check("abort_busy", busy, 0);
        check("abort_pass", pass, 0);
        check("abort_result", result, 0);
        rst = 1'b0;
        ula_rst = 1'b1;
        @(negedge clk);
        ula_rst = 1'b0;
        k = 0;
        repeat (50) begin @(negedge clk); if (done === 1'b1) k++; end
        check("abort_no_done", k, 0);
        run_and_check(3'd5, 3'd3, 3'b010, 6'd15, "after_abort");

        // minimum timing instance
        d0 = done2_cnt;
        widths2.delete();
        @(negedge clk);
        start2 = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (done2_cnt == d0 && k < 200) begin @(negedge clk); k++; end
        if (done2_cnt == d0) check("fast_timeout", 0, 1);
        check("fast_latency", done2_cyc - n, LAT2);
        check("fast_npress", widths2.size(), 5);
        foreach (widths2[i]) check("fast_presswidth", widths2[i], 1);
        check("fast_pass", pass2, 1);
        check("fast_zero", zero2, 1);
        check("fast_result", result2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
